// File: rtl/bus_fanout_if.sv
// Bundle of the initiator request/response signals and the shared target bus
// seen by the fan-out splitter. The slave view belongs to the splitter itself;
// the master view is the surroundings (initiator plus targets).
interface bus_fanout_if #(
    parameter int Count     = 4,
    parameter int Width     = 32,
    parameter int AddrWidth = 16
);
    localparam int SelBits = $clog2(Count);

    // initiator request
    logic                           req_valid;
    logic                           req_ready;
    logic [AddrWidth-1:0]           req_addr;
    logic                           req_write;
    logic [Width-1:0]               req_wdata;

    // initiator response
    logic                           resp_valid;
    logic [Width-1:0]               resp_rdata;
    logic                           resp_error;

    // shared target lines
    logic [Count-1:0]               tgt_sel;
    logic [AddrWidth-SelBits-1:0]   tgt_addr;
    logic                           tgt_write;
    logic [Width-1:0]               tgt_wdata;
    logic [Count-1:0]               tgt_ack;
    logic [Width-1:0]               tgt_rdata [0:Count-1];

    modport master (
        output req_valid, req_addr, req_write, req_wdata, tgt_ack, tgt_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
               tgt_sel, tgt_addr, tgt_write, tgt_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_wdata, tgt_ack, tgt_rdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
               tgt_sel, tgt_addr, tgt_write, tgt_wdata
    );
endinterface

// File: rtl/bus_fanout.sv
// Initiator-side splitter for the shared peripheral bus. The top address bits
// pick one of Count targets; the request is latched and driven onto the shared
// target lines, and the selected target's ack (or a timeout, or a decode error
// for an index with no target behind it) produces a single response strobe.
module bus_fanout #(
    parameter int Count         = 4,
    parameter int Width         = 32,
    parameter int AddrWidth     = 16,
    parameter int TimeoutCycles = 15
) (
    input  logic        clk,
    input  logic        reset,
    bus_fanout_if.slave bus
);
    localparam int SelBits   = $clog2(Count);
    localparam int LocalBits = AddrWidth - SelBits;
    localparam int CntBits   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [SelBits:0]   CountLimit = (SelBits+1)'(Count);
    localparam logic [CntBits-1:0] LastWait   = CntBits'(TimeoutCycles - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t               state;
    logic [SelBits-1:0]   sel_idx;
    logic [CntBits-1:0]   wait_count;
    logic [SelBits-1:0]   req_idx;
    logic                 req_in_range;

    // The target index lives in the top address bits; with a non-power-of-2
    // Count some index values have no target and must give a decode error.
    assign req_idx      = bus.req_addr[AddrWidth-1 -: SelBits];
    assign req_in_range = ({1'b0, req_idx} < CountLimit);

    // Request/response sequencer; every bus-facing output is a register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            sel_idx        <= '0;
            wait_count     <= '0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_error <= 1'b0;
            bus.resp_rdata <= '0;
            bus.tgt_sel    <= '0;
            bus.tgt_addr   <= '0;
            bus.tgt_write  <= 1'b0;
            bus.tgt_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        sel_idx       <= req_idx;
                        wait_count    <= '0;
                        bus.req_ready <= 1'b0;
                        bus.tgt_addr  <= bus.req_addr[LocalBits-1:0];
                        bus.tgt_write <= bus.req_write;
                        bus.tgt_wdata <= bus.req_wdata;
                        if (req_in_range) begin
                            state       <= WAIT;
                            bus.tgt_sel <= Count'(1) << req_idx;
                        end else begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_error <= 1'b1;
                            bus.resp_rdata <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (bus.tgt_ack[sel_idx]) begin
                        state          <= RESP;
                        bus.tgt_sel    <= '0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= 1'b0;
                        bus.resp_rdata <= bus.tgt_write ? '0 : bus.tgt_rdata[sel_idx];
                    end else if (wait_count == LastWait) begin
                        state          <= RESP;
                        bus.tgt_sel    <= '0;
                        bus.resp_valid <= 1'b1;
                        bus.resp_error <= 1'b1;
                        bus.resp_rdata <= '0;
                    end else begin
                        wait_count <= wait_count + 1'b1;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_error <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                default: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    bus.tgt_sel   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_fanout.sv
// Bench for bus_fanout: directed scenarios with literal expectations, then a
// long randomized run, all watched by a per-cycle comparison against a
// transaction-timeline model of the splitter.
module tb_bus_fanout;
    localparam int Count         = 4;
    localparam int Width         = 32;
    localparam int AddrWidth     = 16;
    localparam int TimeoutCycles = 15;
    localparam int SelBits       = $clog2(Count);
    localparam int LocalBits     = AddrWidth - SelBits;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    bit   check_en = 1'b0;

    int n_vectors     = 0;
    int n_miscompares = 0;
    int n_accepts     = 0;

    bus_fanout_if #(.Count(Count), .Width(Width), .AddrWidth(AddrWidth)) bus ();
    bus_fanout_if #(.Count(3),     .Width(Width), .AddrWidth(AddrWidth)) bus3 ();

    bus_fanout #(
        .Count(Count), .Width(Width), .AddrWidth(AddrWidth), .TimeoutCycles(TimeoutCycles)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    bus_fanout #(
        .Count(3), .Width(Width), .AddrWidth(AddrWidth), .TimeoutCycles(TimeoutCycles)
    ) dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [AddrWidth-1:0] a,
                                 input logic w, input logic [Width-1:0] d);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_write = w;
        bus.req_wdata = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setTargets(input logic [Count-1:0] ack, input logic [Width-1:0] fill);
        bus.tgt_ack = ack;
        for (int i = 0; i < Count; i++) bus.tgt_rdata[i] = fill;
    endtask

    // Timeline model: each accepted request is described by its accept edge
    // and the edge after which its response strobe is visible.
    bit                   m_active  = 1'b0;
    int                   edge_no   = 0;
    int                   m_accept  = 0;
    int                   m_resp    = -1;
    int                   m_idx     = 0;
    bit                   m_good    = 1'b0;
    logic                 m_write   = 1'b0;
    logic [LocalBits-1:0] m_addr_lo = '0;
    logic [Width-1:0]     m_wdata   = '0;
    logic [Width-1:0]     m_rdata   = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active  = 1'b0;
            edge_no   = 0;
            m_resp    = -1;
            m_addr_lo = '0;
            m_write   = 1'b0;
            m_wdata   = '0;
            m_rdata   = '0;
        end else begin
            edge_no++;
            if (m_active) begin
                if (m_resp < 0) begin
                    if (bus.tgt_ack[m_idx]) begin
                        m_resp  = edge_no;
                        m_good  = 1'b1;
                        m_rdata = m_write ? '0 : bus.tgt_rdata[m_idx];
                    end else if (edge_no - m_accept == TimeoutCycles) begin
                        m_resp  = edge_no;
                        m_good  = 1'b0;
                        m_rdata = '0;
                    end
                end else if (edge_no == m_resp + 1) begin
                    m_active = 1'b0;
                end
            end else if (bus.req_valid) begin
                n_accepts++;
                m_active  = 1'b1;
                m_accept  = edge_no;
                m_resp    = -1;
                m_idx     = int'(bus.req_addr) / (1 << LocalBits);
                m_addr_lo = LocalBits'(int'(bus.req_addr) % (1 << LocalBits));
                m_write   = bus.req_write;
                m_wdata   = bus.req_wdata;
                if (m_idx >= Count) begin
                    m_resp  = edge_no;
                    m_good  = 1'b0;
                    m_rdata = '0;
                end
            end
        end
    end

    // Compare every DUT output against the model in mid-cycle.
    always @(negedge clk) begin
        if (check_en && !reset) begin
            logic             exp_valid;
            logic [Count-1:0] exp_sel;
            exp_valid = m_active && (m_resp == edge_no);
            exp_sel   = (m_active && m_resp < 0) ? (Count'(1) << m_idx) : '0;
            checkOutput("req_ready",  bus.req_ready,  !m_active);
            checkOutput("resp_valid", bus.resp_valid, exp_valid);
            checkOutput("resp_rdata", bus.resp_rdata, exp_valid ? m_rdata : '0);
            checkOutput("tgt_sel",    bus.tgt_sel,    exp_sel);
            checkOutput("tgt_addr",   bus.tgt_addr,   m_addr_lo);
            checkOutput("tgt_write",  bus.tgt_write,  m_write);
            checkOutput("tgt_wdata",  bus.tgt_wdata,  m_wdata);
            if (exp_valid) checkOutput("resp_error", bus.resp_error, !m_good);
        end
    end

    initial begin
        int last_accepts;
        int ack_pct [Count];
        int pct_table [4];
        pct_table = '{0, 5, 30, 100};

        applyStimulus(1'b0, '0, 1'b0, '0);
        setTargets('0, '0);
        bus3.req_valid = 1'b0;
        bus3.req_addr  = '0;
        bus3.req_write = 1'b0;
        bus3.req_wdata = '0;
        bus3.tgt_ack   = '0;
        for (int i = 0; i < 3; i++) bus3.tgt_rdata[i] = '0;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        check_en = 1'b1;
        #1;
        checkOutput("reset req_ready",  bus.req_ready,  1'b1);
        checkOutput("reset resp_valid", bus.resp_valid, 1'b0);
        checkOutput("reset tgt_sel",    bus.tgt_sel,    4'b0000);
        checkOutput("reset resp_rdata", bus.resp_rdata, 32'h0);
        checkOutput("reset tgt_wdata",  bus.tgt_wdata,  32'h0);
        tick();

        // Read of target 2, acked three cycles after select.
        setTargets('0, 32'hFFFF_FFFF);
        bus.tgt_rdata[2] = 32'hDEAD_BEEF;
        applyStimulus(1'b1, 16'h8012, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0);
        checkOutput("t1 tgt_sel",  bus.tgt_sel,  4'b0100);
        checkOutput("t1 tgt_addr", bus.tgt_addr, 14'h0012);
        tick();
        checkOutput("t1 early resp", bus.resp_valid, 1'b0);
        tick();
        bus.tgt_ack = 4'b0100;
        tick();
        bus.tgt_ack = 4'b0000;
        checkOutput("t1 resp_valid", bus.resp_valid, 1'b1);
        checkOutput("t1 resp_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
        checkOutput("t1 resp_error", bus.resp_error, 1'b0);
        tick();
        checkOutput("t1 single strobe", bus.resp_valid, 1'b0);
        checkOutput("t1 ready again",   bus.req_ready,  1'b1);

        // Write to target 0 with the ack already waiting.
        setTargets(4'b0001, 32'hFFFF_FFFF);
        applyStimulus(1'b1, 16'h0004, 1'b1, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0);
        checkOutput("t2 tgt_write", bus.tgt_write, 1'b1);
        checkOutput("t2 tgt_wdata", bus.tgt_wdata, 32'h1234_5678);
        checkOutput("t2 tgt_sel",   bus.tgt_sel,   4'b0001);
        tick();
        bus.tgt_ack = 4'b0000;
        checkOutput("t2 resp_valid", bus.resp_valid, 1'b1);
        checkOutput("t2 resp_rdata", bus.resp_rdata, 32'h0);
        checkOutput("t2 resp_error", bus.resp_error, 1'b0);
        checkOutput("t2 ready low",  bus.req_ready,  1'b0);
        tick();
        checkOutput("t2 ready back", bus.req_ready,  1'b1);

        // Target 1 silent while target 3 acks: timeout.
        setTargets(4'b1000, 32'h5555_AAAA);
        applyStimulus(1'b1, 16'h4000, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0);
        for (int i = 0; i < TimeoutCycles; i++) begin
            checkOutput("t3 wait sel",  bus.tgt_sel,    4'b0010);
            checkOutput("t3 wait resp", bus.resp_valid, 1'b0);
            tick();
        end
        checkOutput("t3 resp_valid", bus.resp_valid, 1'b1);
        checkOutput("t3 resp_error", bus.resp_error, 1'b1);
        checkOutput("t3 resp_rdata", bus.resp_rdata, 32'h0);
        bus.tgt_ack = 4'b0000;
        tick();

        // Ack arriving on the very edge the wait expires: ack wins.
        setTargets(4'b0000, 32'hFFFF_FFFF);
        bus.tgt_rdata[1] = 32'hCAFE_F00D;
        applyStimulus(1'b1, 16'h4abc, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0);
        for (int i = 0; i < TimeoutCycles - 1; i++) tick();
        checkOutput("t6 no resp yet", bus.resp_valid, 1'b0);
        bus.tgt_ack = 4'b0010;
        tick();
        bus.tgt_ack = 4'b0000;
        checkOutput("t6 resp_valid", bus.resp_valid, 1'b1);
        checkOutput("t6 resp_error", bus.resp_error, 1'b0);
        checkOutput("t6 resp_rdata", bus.resp_rdata, 32'hCAFE_F00D);
        tick();

        // Three-target splitter: index 3 has no target behind it.
        bus3.req_valid = 1'b1;
        bus3.req_addr  = 16'hC000;
        tick();
        bus3.req_valid = 1'b0;
        checkOutput("t4 tgt_sel",    bus3.tgt_sel,    3'b000);
        checkOutput("t4 resp_valid", bus3.resp_valid, 1'b1);
        checkOutput("t4 resp_error", bus3.resp_error, 1'b1);
        checkOutput("t4 resp_rdata", bus3.resp_rdata, 32'h0);
        tick();
        checkOutput("t4 resp done",  bus3.resp_valid, 1'b0);
        checkOutput("t4 ready back", bus3.req_ready,  1'b1);

        // Asynchronous reset in the middle of a wait.
        setTargets(4'b0000, 32'h0);
        applyStimulus(1'b1, 16'h8000, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0);
        tick();
        #2 reset = 1'b1;
        #1;
        checkOutput("t5 sel cleared", bus.tgt_sel,    4'b0000);
        checkOutput("t5 ready set",   bus.req_ready,  1'b1);
        checkOutput("t5 no resp",     bus.resp_valid, 1'b0);
        @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("t5 silent after reset", bus.resp_valid, 1'b0);
        end
        bus.tgt_rdata[3] = 32'h0BAD_F00D;
        bus.tgt_ack      = 4'b1000;
        applyStimulus(1'b1, 16'hC010, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0);
        tick();
        bus.tgt_ack = 4'b0000;
        checkOutput("t5 new resp_valid", bus.resp_valid, 1'b1);
        checkOutput("t5 new resp_rdata", bus.resp_rdata, 32'h0BAD_F00D);
        checkOutput("t5 new resp_error", bus.resp_error, 1'b0);
        tick();

        // Randomized traffic; requests are held until the model sees them taken.
        for (int i = 0; i < Count; i++) ack_pct[i] = 0;
        last_accepts = n_accepts;
        for (int c = 0; c < 4000; c++) begin
            if (!bus.req_valid || n_accepts != last_accepts) begin
                last_accepts = n_accepts;
                if ($urandom_range(0, 3) == 0) begin
                    bus.req_valid = 1'b0;
                end else begin
                    applyStimulus(1'b1, AddrWidth'($urandom), 1'($urandom_range(0, 1)), $urandom);
                    for (int i = 0; i < Count; i++) ack_pct[i] = pct_table[$urandom_range(0, 3)];
                end
            end
            for (int i = 0; i < Count; i++) begin
                bus.tgt_ack[i]   = ($urandom_range(0, 99) < ack_pct[i]);
                bus.tgt_rdata[i] = $urandom;
            end
            tick();
        end
        applyStimulus(1'b0, 16'h0, 1'b0, 32'h0);
        setTargets('0, '0);
        repeat (TimeoutCycles + 4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/bus_fanout.md
Name: bus_fanout

Overview:
- Initiator-side splitter for the shared peripheral bus. Takes one initiator request and decodes its upper address bits into a one-hot target select. Drives the shared target address/data lines, then waits for the selected target's acknowledge.
- Returns the read word from the selected target only, with a per-request timeout and a decode-error response.
- Opposite direction of the OR-combining read-data reducer: this block fans a request out, where the reducer merges responses in.

Parameters:
- Count, 4, number of targets (>=2).
- Width, 32, data word width.
- AddrWidth, 16, request address width.
- TimeoutCycles, 15, maximum wait cycles for a target ack before an error response (>=1).
- localparam SelBits = $clog2(Count): width of the target index field, taken from the top of the address.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  initiator request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  AddrWidth  request address.
- req_write  in  1  1 = write, 0 = read.
- req_wdata  in  Width  write data.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  Width  read data; 0 on writes and errors.
- resp_error  out  1  qualifies resp_valid: decode error or timeout.
- tgt_sel  out  Count  one-hot target select.
- tgt_addr  out  AddrWidth-SelBits  target-local address (lower bits of the latched address).
- tgt_write  out  1  latched write flag.
- tgt_wdata  out  Width  latched write data.
- tgt_ack  in  Count  per-target acknowledge.
- tgt_rdata  in  Width x [0:Count-1]  per-target read words (unpacked array).

Behaviour:
- Reset (asynchronous, active-high; any cycle, including mid-transaction):
  - Go to IDLE.
  - Reset values: req_ready=1; resp_valid=0, resp_error=0, resp_rdata=0; tgt_sel=0; tgt_addr=0, tgt_write=0, tgt_wdata=0; timeout counter=0.
  - Any transaction in flight is dropped silently; no response is produced.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch addr, write and wdata; index = req_addr[AddrWidth-1 -: SelBits].
  - If index < Count: go to WAIT, tgt_sel[index]=1 from the next cycle, counter cleared.
  - If index >= Count (non-power-of-2 Count): go to RESP with resp_error=1 and rdata=0; no tgt_sel is ever asserted.
- WAIT:
  - req_ready=0. tgt_sel holds one-hot. tgt_addr, tgt_write and tgt_wdata hold their latched values.
  - Each edge: if tgt_ack[index]=1, capture tgt_rdata[index] into resp_rdata (0 if write), set resp_error=0, go to RESP.
  - Otherwise, if counter == TimeoutCycles-1: go to RESP with resp_error=1 and rdata=0.
  - Otherwise increment the counter.
  - tgt_sel clears on the same edge that leaves WAIT.
  - Acks from non-selected targets are ignored.
  - tgt_rdata from non-selected targets never reaches resp_rdata.
- RESP:
  - resp_valid=1 for exactly one cycle. req_ready=0. tgt_sel=0.
  - Next edge: go to IDLE, resp_valid=0, resp_rdata returns to 0.
- Latency:
  - Request accepted at edge N; tgt_sel high in cycle N+1.
  - Ack sampled at edge M; resp_valid high in cycle M+1.
  - Minimum accept-to-response latency is 2 cycles (ack already high at edge N+1).
  - Back-to-back throughput is one request every 3 cycles minimum.
- Timeout: the error response appears TimeoutCycles+1 cycles after accept.
- Ack and timeout on the same edge: ack wins, response is good with resp_error=0.
- No backpressure on resp_valid; the initiator must always accept the response.
- req_valid while req_ready=0 is ignored and not queued; the initiator must hold the request.

Test Plan:
- Read target 2 (Count=4, addr=0x8012), target 2 acks 3 cycles after sel with rdata 0xDEADBEEF, all other tgt_rdata=0xFFFFFFFF -> tgt_sel=4'b0100, tgt_addr=0x0012; one resp_valid with rdata=0xDEADBEEF, error=0.
- Write target 0 (addr=0x0004, wdata=0x12345678), ack at edge N+1 -> tgt_write=1, tgt_wdata=0x12345678; resp_valid in cycle N+2 with rdata=0, error=0; req_ready back to 1 in cycle N+3.
- Target 1 never acks while target 3 acks continuously (TimeoutCycles=15) -> no response for 15 cycles; resp_valid with error=1 and rdata=0 in cycle N+16; tgt_sel=4'b0010 throughout the wait.
- Count=3, addr with index 3 -> tgt_sel stays 0; resp_valid with error=1 one cycle after accept.
- Reset asserted asynchronously mid-WAIT (between edges) -> tgt_sel=0 and req_ready=1 immediately; no resp_valid after reset release; a new request completes normally.
- Ack arrives on the edge where the counter hits TimeoutCycles-1 -> good response, error=0, rdata = target data.
